fifo_sync_ctrl: RTL and testbench

Parametrised single-clock FIFO with an integrated, registered controller state machine. It generalises the team's FIFO next-state controller with configurable width and depth, a storage array, concurrent read/write, programmable almost-full and almost-empty thresholds, occupancy count, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain. The exported `state` code is compatible with the existing FIFO state encoding, plus one new state.

---
 rtl/fifo_sync_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fifo_sync_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_ctrl
// Description : Single-clock FIFO with registered flags, thresholds, sticky
//               error flags and an outcome-encoding controller state.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [2:0]                 state,
    output logic                       wr_err,
    output logic                       rd_err,
    output logic                       ovf_sticky,
    output logic                       udf_sticky,
    input  logic                       err_clr
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    typedef enum logic [2:0] {
        ST_INIT   = 3'b000,
        ST_IDLE   = 3'b001,
        ST_WRITE  = 3'b010,
        ST_WR_ERR = 3'b011,
        ST_READ   = 3'b100,
        ST_RD_ERR = 3'b101,
        ST_RDWR   = 3'b110
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_count_nxt;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_wr_err;
    logic              r_rd_err;
    logic              r_ovf;
    logic              r_udf;
    state_t            r_state;
    state_t            w_state_nxt;

    logic w_wr_ok;
    logic w_rd_ok;
    logic w_wr_rej;
    logic w_rd_rej;

    // Acceptance uses the registered flags, so a full FIFO rejects a write
    // even when a read in the same cycle would free a slot.
    assign w_wr_ok  = wr_en && !r_full;
    assign w_rd_ok  = rd_en && !r_empty;
    assign w_wr_rej = wr_en && r_full;
    assign w_rd_rej = rd_en && r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + c_CW'(1);
            2'b01:   w_count_nxt = r_count - c_CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = ST_INIT;
        case (r_state)
            ST_INIT, ST_IDLE, ST_WRITE, ST_WR_ERR,
            ST_READ, ST_RD_ERR, ST_RDWR: begin
                if (w_wr_rej)                w_state_nxt = ST_WR_ERR;
                else if (w_rd_rej)           w_state_nxt = ST_RD_ERR;
                else if (w_wr_ok && w_rd_ok) w_state_nxt = ST_RDWR;
                else if (w_wr_ok)            w_state_nxt = ST_WRITE;
                else if (w_rd_ok)            w_state_nxt = ST_READ;
                else                         w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_wr_err   <= 1'b0;
            r_rd_err   <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_rd_ok) begin
                r_rd_ptr  <= r_rd_ptr + c_AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_rd_ok;
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == c_CW'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
            r_afull    <= (w_count_nxt >= c_CW'(AF_THRESH));
            r_aempty   <= (w_count_nxt <= c_CW'(AE_THRESH));
            r_wr_err   <= w_wr_rej;
            r_rd_err   <= w_rd_rej;
            // A new error outranks a coincident clear.
            r_ovf      <= w_wr_rej || (r_ovf && !err_clr);
            r_udf      <= w_rd_rej || (r_udf && !err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign state        = r_state;
    assign wr_err       = r_wr_err;
    assign rd_err       = r_rd_err;
    assign ovf_sticky   = r_ovf;
    assign udf_sticky   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_ctrl
// Description : Directed and randomized bench for fifo_sync_ctrl against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_ctrl;

    localparam int c_DW    = 8;
    localparam int c_DEPTH = 8;
    localparam int c_AF    = 6;
    localparam int c_AE    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [c_DW-1:0]  wr_data = '0;
    logic             rd_en = 1'b0;
    logic [c_DW-1:0]  rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       count;
    logic [2:0]       state;
    logic             wr_err;
    logic             rd_err;
    logic             ovf_sticky;
    logic             udf_sticky;
    logic             err_clr = 1'b0;

    fifo_sync_ctrl #(
        .DATA_W(c_DW), .DEPTH(c_DEPTH), .AF_THRESH(c_AF), .AE_THRESH(c_AE)
    ) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .state(state),
        .wr_err(wr_err), .rd_err(rd_err), .ovf_sticky(ovf_sticky),
        .udf_sticky(udf_sticky), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the FIFO contents as a queue plus expected outputs.
    logic [c_DW-1:0] m_q[$];
    logic [c_DW-1:0] m_rd_data;
    logic            m_rd_valid;
    logic [2:0]      m_state;
    logic            m_wr_err, m_rd_err, m_ovf, m_udf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_state    = 3'b000;
        m_wr_err   = 1'b0;
        m_rd_err   = 1'b0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check_val("rd_data",      32'(rd_data),      32'(m_rd_data));
        check_val("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
        check_val("count",        32'(count),        32'(n));
        check_val("full",         32'(full),         32'(n == c_DEPTH));
        check_val("empty",        32'(empty),        32'(n == 0));
        check_val("almost_full",  32'(almost_full),  32'(n >= c_AF));
        check_val("almost_empty", 32'(almost_empty), 32'(n <= c_AE));
        check_val("state",        32'(state),        32'(m_state));
        check_val("wr_err",       32'(wr_err),       32'(m_wr_err));
        check_val("rd_err",       32'(rd_err),       32'(m_rd_err));
        check_val("ovf_sticky",   32'(ovf_sticky),   32'(m_ovf));
        check_val("udf_sticky",   32'(udf_sticky),   32'(m_udf));
    endtask

    // One clock of stimulus; the model applies the acceptance rules to the
    // occupancy seen before the edge.
    task automatic step(input logic wr, input logic [c_DW-1:0] wd, input logic rd, input logic clr);
        bit was_full, was_empty, wr_ok, rd_ok, wr_rej, rd_rej;
        @(negedge clk);
        wr_en = wr; wr_data = wd; rd_en = rd; err_clr = clr;
        @(posedge clk);
        was_full  = (m_q.size() == c_DEPTH);
        was_empty = (m_q.size() == 0);
        wr_ok  = wr && !was_full;
        rd_ok  = rd && !was_empty;
        wr_rej = wr && was_full;
        rd_rej = rd && was_empty;
        if (rd_ok) m_rd_data = m_q.pop_front();
        if (wr_ok) m_q.push_back(wd);
        m_rd_valid = rd_ok;
        m_wr_err   = wr_rej;
        m_rd_err   = rd_rej;
        m_ovf      = wr_rej || (m_ovf && !clr);
        m_udf      = rd_rej || (m_udf && !clr);
        if (wr_rej)             m_state = 3'b011;
        else if (rd_rej)        m_state = 3'b101;
        else if (wr_ok && rd_ok) m_state = 3'b110;
        else if (wr_ok)         m_state = 3'b010;
        else if (rd_ok)         m_state = 3'b100;
        else                    m_state = 3'b001;
        #1;
        check_all();
    endtask

    // Reset asserted between edges must take effect without a clock edge.
    task automatic async_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        check_all();
        rst = 1'b0;
        #1;
        check_val("init_state", 32'(state), 32'(0));
        step(0, 0, 0, 0);
        check_val("idle_state", 32'(state), 32'(1));

        async_reset();
        step(0, 0, 0, 0);

        // Fill, overflow, sticky clear
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hEE, 0, 0);
        check_val("ovf_state", 32'(state), 32'(3));
        step(0, 0, 0, 1);
        check_val("ovf_cleared", 32'(ovf_sticky), 32'(0));

        // Drain, underflow, then a second pass to wrap pointers
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check_val("udf_state", 32'(state), 32'(5));
        for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

        // Concurrent access at count 4
        for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h10 + i), 1, 0);
        check_val("rdwr_count", 32'(count), 32'(4));

        // Both requests on full, then on empty
        for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0);
        step(1, 8'h77, 1, 0);
        check_val("full_both_count", 32'(count), 32'(7));
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        step(1, 8'h55, 1, 0);
        check_val("empty_both_count", 32'(count), 32'(1));

        // Mid-burst reset at count 5, then an underflowing read
        for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + i), 0, 0);
        async_reset();
        step(0, 0, 1, 0);
        check_val("post_rst_udf", 32'(rd_err), 32'(1));

        // Randomized traffic with occasional sticky clears
        for (int i = 0; i < 600; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 8);
            step(w, 8'($urandom), r, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
